rv32im_csr_ctrl: RTL and testbench

//  Sequencer in front of rv32im_csr_regfile. Accepts CSR instructions from decode and runs the read-modify-write on the regfile.

---
 rtl/rv32im_csr_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_rv32im_csr_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32im_csr_ctrl.sv
// rv32im_csr_ctrl: owns the CSR regfile access port.
// It sequences CSR read-modify-write instructions, trap entry and mret.
// It returns the old CSR value to writeback and a PC redirect to fetch.
module rv32im_csr_ctrl #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned CSR_AW = 12
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [2:0]        req_funct3_i,
    input  logic [CSR_AW-1:0] req_addr_i,
    input  logic [XLEN-1:0]   req_src_i,
    input  logic              req_src_zero_i,
    input  logic              req_rd_zero_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [XLEN-1:0]   resp_data_o,
    output logic              resp_illegal_o,
    input  logic              trap_valid_i,
    output logic              trap_ready_o,
    input  logic [XLEN-1:0]   trap_cause_i,
    input  logic [XLEN-1:0]   trap_pc_i,
    input  logic              mret_valid_i,
    output logic              mret_ready_o,
    output logic              redirect_valid_o,
    output logic [XLEN-1:0]   redirect_pc_o,
    output logic [CSR_AW-1:0] csr_addr_o,
    output logic [XLEN-1:0]   csr_wdata_o,
    output logic              csr_write_en_o,
    output logic              csr_read_en_o,
    input  logic [XLEN-1:0]   csr_rdata_i,
    output logic              busy_o
);

    localparam logic [CSR_AW-1:0] CSR_MSTATUS = CSR_AW'(12'h300);
    localparam logic [CSR_AW-1:0] CSR_MTVEC   = CSR_AW'(12'h305);
    localparam logic [CSR_AW-1:0] CSR_MEPC    = CSR_AW'(12'h341);
    localparam logic [CSR_AW-1:0] CSR_MCAUSE  = CSR_AW'(12'h342);

    typedef enum logic [3:0] {
        S_IDLE, S_EXEC, S_RESP,
        S_T_EPC, S_T_CAUSE, S_T_STAT, S_T_VEC,
        S_M_STAT, S_M_EPC
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          f3_q;
    logic [CSR_AW-1:0]   addr_q;
    logic [XLEN-1:0]     src_q;
    logic                src_zero_q;
    logic                rd_zero_q;
    logic [XLEN-1:0]     cause_q;
    logic [XLEN-1:0]     pc_q;
    logic [XLEN-1:0]     resp_data_q;
    logic                resp_illegal_q;
    logic [XLEN-1:0]     old_c;
    logic [XLEN-1:0]     vec_base_c;
    logic                illegal_c;
    logic                rw_type_c;
    logic                idle_c;

    assign idle_c       = (state_q == S_IDLE);
    assign trap_ready_o = idle_c & trap_valid_i;
    assign mret_ready_o = idle_c & ~trap_valid_i & mret_valid_i;
    assign req_ready_o  = idle_c & ~trap_valid_i & ~mret_valid_i;

    assign illegal_c    = (f3_q == 3'b000) | (f3_q == 3'b100);
    assign rw_type_c    = (f3_q[1:0] == 2'b01);

    assign resp_valid_o   = (state_q == S_RESP);
    assign resp_data_o    = resp_data_q;
    assign resp_illegal_o = resp_illegal_q;
    assign busy_o         = ~idle_c;

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Latch accepted request/trap fields and the EXEC result
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            f3_q           <= '0;
            addr_q         <= '0;
            src_q          <= '0;
            src_zero_q     <= 1'b0;
            rd_zero_q      <= 1'b0;
            cause_q        <= '0;
            pc_q           <= '0;
            resp_data_q    <= '0;
            resp_illegal_q <= 1'b0;
        end else begin
            if (req_valid_i && req_ready_o) begin
                f3_q       <= req_funct3_i;
                addr_q     <= req_addr_i;
                src_q      <= req_src_i;
                src_zero_q <= req_src_zero_i;
                rd_zero_q  <= req_rd_zero_i;
            end
            if (trap_ready_o) begin
                cause_q <= trap_cause_i;
                pc_q    <= trap_pc_i;
            end
            if (state_q == S_EXEC) begin
                resp_data_q    <= old_c;
                resp_illegal_q <= illegal_c;
            end
        end
    end

    // Next state and regfile/redirect drive per state
    always_comb begin
        state_d          = state_q;
        csr_addr_o       = '0;
        csr_wdata_o      = '0;
        csr_write_en_o   = 1'b0;
        csr_read_en_o    = 1'b0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = '0;
        old_c            = '0;
        vec_base_c       = {csr_rdata_i[XLEN-1:2], 2'b00};
        case (state_q)
            S_IDLE: begin
                if (trap_valid_i)      state_d = S_T_EPC;
                else if (mret_valid_i) state_d = S_M_STAT;
                else if (req_valid_i)  state_d = S_EXEC;
            end
            S_EXEC: begin
                csr_addr_o     = addr_q;
                csr_read_en_o  = ~illegal_c & ~(rw_type_c & rd_zero_q);
                old_c          = csr_read_en_o ? csr_rdata_i : '0;
                case (f3_q[1:0])
                    2'b01:   csr_wdata_o = src_q;
                    2'b10:   csr_wdata_o = old_c | src_q;
                    2'b11:   csr_wdata_o = old_c & ~src_q;
                    default: csr_wdata_o = '0;
                endcase
                csr_write_en_o = ~illegal_c & (rw_type_c | ~src_zero_q);
                state_d        = S_RESP;
            end
            S_RESP: begin
                if (resp_ready_i) state_d = S_IDLE;
            end
            S_T_EPC: begin
                csr_addr_o     = CSR_MEPC;
                csr_wdata_o    = {pc_q[XLEN-1:2], 2'b00};
                csr_write_en_o = 1'b1;
                state_d        = S_T_CAUSE;
            end
            S_T_CAUSE: begin
                csr_addr_o     = CSR_MCAUSE;
                csr_wdata_o    = cause_q;
                csr_write_en_o = 1'b1;
                state_d        = S_T_STAT;
            end
            S_T_STAT: begin
                csr_addr_o         = CSR_MSTATUS;
                csr_read_en_o      = 1'b1;
                csr_wdata_o        = csr_rdata_i;
                csr_wdata_o[7]     = csr_rdata_i[3];
                csr_wdata_o[3]     = 1'b0;
                csr_wdata_o[12:11] = 2'b11;
                csr_write_en_o     = 1'b1;
                state_d            = S_T_VEC;
            end
            S_T_VEC: begin
                csr_addr_o       = CSR_MTVEC;
                csr_read_en_o    = 1'b1;
                redirect_valid_o = 1'b1;
                if ((csr_rdata_i[1:0] == 2'b01) && cause_q[XLEN-1])
                    redirect_pc_o = vec_base_c + XLEN'({cause_q[XLEN-2:0], 2'b00});
                else
                    redirect_pc_o = vec_base_c;
                state_d          = S_IDLE;
            end
            S_M_STAT: begin
                csr_addr_o         = CSR_MSTATUS;
                csr_read_en_o      = 1'b1;
                csr_wdata_o        = csr_rdata_i;
                csr_wdata_o[3]     = csr_rdata_i[7];
                csr_wdata_o[7]     = 1'b1;
                csr_wdata_o[12:11] = 2'b11;
                csr_write_en_o     = 1'b1;
                state_d            = S_M_EPC;
            end
            S_M_EPC: begin
                csr_addr_o       = CSR_MEPC;
                csr_read_en_o    = 1'b1;
                redirect_valid_o = 1'b1;
                redirect_pc_o    = {csr_rdata_i[XLEN-1:2], 2'b00};
                state_d          = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_rv32im_csr_ctrl.sv
// Directed bench for rv32im_csr_ctrl with a small behavioural CSR regfile.
module tb_rv32im_csr_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [2:0]  req_funct3;
    logic [11:0] req_addr;
    logic [31:0] req_src;
    logic        req_src_zero, req_rd_zero;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_data;
    logic        resp_illegal;
    logic        trap_valid, trap_ready;
    logic [31:0] trap_cause, trap_pc;
    logic        mret_valid, mret_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        csr_write_en, csr_read_en;
    logic [31:0] csr_rdata;
    logic        busy;

    logic [31:0] csr_mem [4096];
    logic        clr, poke_en;
    logic [11:0] poke_addr;
    logic [31:0] poke_data;
    int unsigned wr_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rv32im_csr_ctrl #(.XLEN(32), .CSR_AW(12)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_src_i(req_src),
        .req_src_zero_i(req_src_zero), .req_rd_zero_i(req_rd_zero),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_data_o(resp_data), .resp_illegal_o(resp_illegal),
        .trap_valid_i(trap_valid), .trap_ready_o(trap_ready),
        .trap_cause_i(trap_cause), .trap_pc_i(trap_pc),
        .mret_valid_i(mret_valid), .mret_ready_o(mret_ready),
        .redirect_valid_o(redirect_valid), .redirect_pc_o(redirect_pc),
        .csr_addr_o(csr_addr), .csr_wdata_o(csr_wdata),
        .csr_write_en_o(csr_write_en), .csr_read_en_o(csr_read_en),
        .csr_rdata_i(csr_rdata), .busy_o(busy)
    );

    // Regfile model: combinational read, write committed at the edge
    assign csr_rdata = csr_mem[csr_addr];

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 4096; i++) csr_mem[i] <= '0;
            wr_cnt <= 0;
        end else if (poke_en) begin
            csr_mem[poke_addr] <= poke_data;
        end else if (csr_write_en) begin
            csr_mem[csr_addr] <= csr_wdata;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [11:0] a, input logic [31:0] d);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        step();
        poke_en = 1'b0;
    endtask

    // One CSR instruction; hold = cycles resp_ready stays low in RESP
    task automatic csr_op(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] src,
                          input logic sz, input logic rz, input int hold,
                          input logic exp_ren, input logic exp_wen, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_data, input logic exp_ill);
        int unsigned wb;
        req_valid = 1'b1; req_funct3 = f3; req_addr = a; req_src = src;
        req_src_zero = sz; req_rd_zero = rz;
        @(negedge clk);
        check("req_ready", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        wb = wr_cnt;
        if (hold > 0) resp_ready = 1'b0;
        @(negedge clk);
        check("exec_addr", 32'(csr_addr), 32'(a));
        check("exec_ren", 32'(csr_read_en), 32'(exp_ren));
        check("exec_wen", 32'(csr_write_en), 32'(exp_wen));
        if (exp_wen) check("exec_wdata", csr_wdata, exp_wdata);
        check("exec_resp_valid", 32'(resp_valid), 32'd0);
        step();
        for (int i = 0; i <= hold; i++) begin
            @(negedge clk);
            check("resp_valid", 32'(resp_valid), 32'd1);
            check("resp_data", resp_data, exp_data);
            check("resp_illegal", 32'(resp_illegal), 32'(exp_ill));
            if (i == hold) resp_ready = 1'b1;
            step();
        end
        check("op_idle", 32'(busy), 32'd0);
        check("op_writes", wr_cnt - wb, 32'(exp_wen));
    endtask

    task automatic trap_seq(input logic [31:0] cause, input logic [31:0] pc,
                            input logic [31:0] exp_epc, input logic [31:0] exp_mstatus,
                            input logic [31:0] exp_target);
        int unsigned wb;
        trap_valid = 1'b1; trap_cause = cause; trap_pc = pc;
        @(negedge clk);
        check("trap_ready", 32'(trap_ready), 32'd1);
        check("trap_mret_ready", 32'(mret_ready), 32'd0);
        check("trap_req_ready", 32'(req_ready), 32'd0);
        step();
        trap_valid = 1'b0;
        wb = wr_cnt;
        @(negedge clk);
        check("t_epc_addr", 32'(csr_addr), 32'h341);
        check("t_epc_wdata", csr_wdata, exp_epc);
        check("t_epc_wen", 32'(csr_write_en), 32'd1);
        check("t_busy_mret_ready", 32'(mret_ready), 32'd0);
        check("t_busy_req_ready", 32'(req_ready), 32'd0);
        check("t_epc_redirect", 32'(redirect_valid), 32'd0);
        step();
        @(negedge clk);
        check("t_cause_addr", 32'(csr_addr), 32'h342);
        check("t_cause_wdata", csr_wdata, cause);
        check("t_cause_redirect", 32'(redirect_valid), 32'd0);
        step();
        @(negedge clk);
        check("t_stat_addr", 32'(csr_addr), 32'h300);
        check("t_stat_wdata", csr_wdata, exp_mstatus);
        check("t_stat_wen", 32'(csr_write_en), 32'd1);
        check("t_stat_redirect", 32'(redirect_valid), 32'd0);
        step();
        @(negedge clk);
        check("t_vec_addr", 32'(csr_addr), 32'h305);
        check("t_vec_wen", 32'(csr_write_en), 32'd0);
        check("t_vec_redirect", 32'(redirect_valid), 32'd1);
        check("t_vec_target", redirect_pc, exp_target);
        step();
        check("trap_idle", 32'(busy), 32'd0);
        check("trap_redirect_off", 32'(redirect_valid), 32'd0);
        check("trap_writes", wr_cnt - wb, 32'd3);
    endtask

    task automatic mret_seq(input logic [31:0] exp_mstatus, input logic [31:0] exp_target);
        mret_valid = 1'b1;
        @(negedge clk);
        check("mret_ready", 32'(mret_ready), 32'd1);
        check("mret_req_ready", 32'(req_ready), 32'd0);
        step();
        mret_valid = 1'b0;
        @(negedge clk);
        check("m_stat_addr", 32'(csr_addr), 32'h300);
        check("m_stat_wdata", csr_wdata, exp_mstatus);
        check("m_stat_wen", 32'(csr_write_en), 32'd1);
        check("m_stat_redirect", 32'(redirect_valid), 32'd0);
        step();
        @(negedge clk);
        check("m_epc_addr", 32'(csr_addr), 32'h341);
        check("m_epc_redirect", 32'(redirect_valid), 32'd1);
        check("m_epc_target", redirect_pc, exp_target);
        step();
        check("mret_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b1; poke_en = 1'b0; poke_addr = '0; poke_data = '0;
        req_valid = 1'b0; req_funct3 = '0; req_addr = '0; req_src = '0;
        req_src_zero = 1'b0; req_rd_zero = 1'b0; resp_ready = 1'b1;
        trap_valid = 1'b0; trap_cause = '0; trap_pc = '0; mret_valid = 1'b0;
        repeat (2) step();
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_wen", 32'(csr_write_en), 32'd0);
        check("rst_redirect", 32'(redirect_valid), 32'd0);
        step();
        rst_n = 1'b1; clr = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", 32'(req_ready), 32'd1);
        step();

        // CSRRW / CSRRS on mstatus
        csr_op(3'b001, 12'h300, 32'hF000_0000, 1'b0, 1'b0, 0, 1'b1, 1'b1, 32'hF000_0000, 32'h0, 1'b0);
        check("mstatus_rw", csr_mem[12'h300], 32'hF000_0000);
        csr_op(3'b010, 12'h300, 32'h0F00_0000, 1'b0, 1'b0, 0, 1'b1, 1'b1, 32'hFF00_0000, 32'hF000_0000, 1'b0);
        check("mstatus_rs", csr_mem[12'h300], 32'hFF00_0000);
        csr_op(3'b010, 12'h300, 32'h0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 32'h0, 32'hFF00_0000, 1'b0);

        // Read-only CSRRC, illegal funct3, CSRRWI with rd=x0
        poke(12'hB00, 32'h0000_1234);
        csr_op(3'b011, 12'hB00, 32'h0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 32'h0, 32'h0000_1234, 1'b0);
        csr_op(3'b100, 12'h300, 32'h5, 1'b0, 1'b0, 0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        check("illegal_no_write", csr_mem[12'h300], 32'hFF00_0000);
        csr_op(3'b101, 12'h340, 32'h1F, 1'b0, 1'b1, 0, 1'b0, 1'b1, 32'h1F, 32'h0, 1'b0);

        // Direct trap
        poke(12'h305, 32'h80);
        poke(12'h300, 32'h8);
        trap_seq(32'h2, 32'h103, 32'h100, 32'h1880, 32'h80);
        check("mepc", csr_mem[12'h341], 32'h100);
        check("mcause", csr_mem[12'h342], 32'h2);
        check("mstatus_trap", csr_mem[12'h300], 32'h1880);

        // Vectored interrupt then mret
        poke(12'h305, 32'h81);
        poke(12'h300, 32'h8);
        trap_seq(32'h8000_0007, 32'h102, 32'h100, 32'h1880, 32'h9C);
        mret_seq(32'h1888, 32'h100);
        check("mstatus_mret", csr_mem[12'h300], 32'h1888);

        // Trap, mret and req all pending: trap, then mret, then req
        mret_valid = 1'b1;
        req_valid = 1'b1; req_funct3 = 3'b001; req_addr = 12'h340; req_src = 32'h55;
        req_src_zero = 1'b0; req_rd_zero = 1'b0;
        trap_seq(32'h3, 32'h300, 32'h300, 32'h1880, 32'h80);
        mret_seq(32'h1888, 32'h300);
        csr_op(3'b001, 12'h340, 32'h55, 1'b0, 1'b0, 3, 1'b1, 1'b1, 32'h55, 32'h1F, 1'b0);
        check("mscratch", csr_mem[12'h340], 32'h55);

        // Reset in T_CAUSE: mepc already committed, mcause untouched
        trap_valid = 1'b1; trap_cause = 32'h5; trap_pc = 32'h404;
        @(negedge clk);
        check("t6_trap_ready", 32'(trap_ready), 32'd1);
        step();
        trap_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_wen", 32'(csr_write_en), 32'd0);
        check("t6_rst_addr", 32'(csr_addr), 32'h0);
        check("t6_rst_redirect", 32'(redirect_valid), 32'd0);
        check("t6_rst_resp_valid", 32'(resp_valid), 32'd0);
        step();
        check("t6_mepc_kept", csr_mem[12'h341], 32'h404);
        check("t6_mcause_old", csr_mem[12'h342], 32'h3);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_req_ready", 32'(req_ready), 32'd1);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
